// File: rtl/mul_issue_ctrl_pkg.sv
// rtl/mul_issue_ctrl_pkg.sv - multiplier instruction encodings, field positions and operand-usage decode
package mul_pkg;

  localparam int INS_W     = 24;
  localparam int CLS_HI    = 23;
  localparam int CLS_LO    = 22;
  localparam int SC_HI     = 21;
  localparam int SC_LO     = 20;
  localparam int OTREG_BIT = 19;
  localparam int DTSTS_HI  = 18;
  localparam int DTSTS_LO  = 15;
  localparam int RN_HI     = 11;
  localparam int RN_LO     = 8;
  localparam int RX_HI     = 7;
  localparam int RX_LO     = 4;
  localparam int RY_HI     = 3;
  localparam int RY_LO     = 0;

  typedef enum logic [1:0] {
    CLS_MR_SAT  = 2'b00,
    CLS_PRODUCT = 2'b01,
    CLS_ACC_ADD = 2'b10,
    CLS_ACC_SUB = 2'b11
  } mul_cls_e;

  typedef enum logic [1:0] {
    SC_MR0 = 2'b00,
    SC_MR1 = 2'b01,
    SC_MR2 = 2'b10,
    SC_SAT = 2'b11
  } mul_sc_e;

  // dtsts: [3:2] operand signedness (UU/SU/US/SS), [1:0] integer/fraction/fraction-rounded
  localparam logic [3:0] DT_UUI  = 4'b0000;
  localparam logic [3:0] DT_UUF  = 4'b0001;
  localparam logic [3:0] DT_UUFR = 4'b0010;
  localparam logic [3:0] DT_SUI  = 4'b0100;
  localparam logic [3:0] DT_SUF  = 4'b0101;
  localparam logic [3:0] DT_SUFR = 4'b0110;
  localparam logic [3:0] DT_USI  = 4'b1000;
  localparam logic [3:0] DT_USF  = 4'b1001;
  localparam logic [3:0] DT_USFR = 4'b1010;
  localparam logic [3:0] DT_SSI  = 4'b1100;
  localparam logic [3:0] DT_SSF  = 4'b1101;
  localparam logic [3:0] DT_SSFR = 4'b1110;

  function automatic logic uses_rx(input logic [1:0] cls, input logic [1:0] sc, input logic otreg);
    return !((cls == CLS_MR_SAT) && (!otreg || (sc == SC_SAT)));
  endfunction

  function automatic logic uses_ry(input logic [1:0] cls);
    return cls != CLS_MR_SAT;
  endfunction

  function automatic logic writes_rn(input logic otreg);
    return !otreg;
  endfunction

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// rtl/mul_issue_ctrl_if.sv - instruction-word valid/ready handshake bundle
interface mul_issue_ctrl_if;
  import mul_pkg::*;

  logic             ins_valid;
  logic [INS_W-1:0] ins_word;
  logic             ins_ready;

  modport master (output ins_valid, output ins_word, input ins_ready);
  modport slave  (input ins_valid, input ins_word, output ins_ready);

endinterface

// File: rtl/mul_issue_ctrl_flag_reg.sv
// rtl/mul_issue_ctrl_flag_reg.sv - ASTAT MV/MN flags and sticky MOS bit
module mul_flag_reg (
  input  logic clk_exe,
  input  logic reset,
  input  logic upd_i,
  input  logic mv_i,
  input  logic mn_i,
  input  logic stky_clr_i,
  output logic astat_mv_o,
  output logic astat_mn_o,
  output logic stky_mos_o
);

  logic mv_q, mv_d;
  logic mn_q, mn_d;
  logic mos_q, mos_d;

  // A set on the same cycle as a clear wins, so an overflow is never lost.
  always_comb begin
    mv_d  = mv_q;
    mn_d  = mn_q;
    mos_d = mos_q;
    if (stky_clr_i) mos_d = 1'b0;
    if (upd_i) begin
      mv_d = mv_i;
      mn_d = mn_i;
      if (mv_i) mos_d = 1'b1;
    end
  end

  always_ff @(posedge clk_exe) begin
    if (!reset) begin
      mv_q  <= 1'b0;
      mn_q  <= 1'b0;
      mos_q <= 1'b0;
    end else begin
      mv_q  <= mv_d;
      mn_q  <= mn_d;
      mos_q <= mos_d;
    end
  end

  assign astat_mv_o = mv_q;
  assign astat_mn_o = mn_q;
  assign stky_mos_o = mos_q;

endmodule

// File: rtl/mul_issue_ctrl.sv
// rtl/mul_issue_ctrl.sv - multiplier issue/writeback controller with Rn read-after-write interlock
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int RF_DATASIZE = 16,
  parameter int RF_ADDRSIZE = 4
) (
  input  logic                   clk_exe,
  input  logic                   reset,
  mul_issue_ctrl_if.slave        ins_if,
  input  logic                   ps_flush,
  input  logic                   ps_stky_clr,
  output logic                   ps_mul_en,
  output logic                   ps_mul_otreg,
  output logic [3:0]             ps_mul_dtsts,
  output logic [1:0]             ps_mul_cls,
  output logic [1:0]             ps_mul_sc,
  output logic [RF_ADDRSIZE-1:0] ps_xb_rdx,
  output logic [RF_ADDRSIZE-1:0] ps_xb_rdy,
  input  logic [RF_DATASIZE-1:0] mul_xb_dt,
  input  logic                   mul_ps_mv,
  input  logic                   mul_ps_mn,
  output logic                   ps_rf_wen,
  output logic [RF_ADDRSIZE-1:0] ps_rf_wadd,
  output logic [RF_DATASIZE-1:0] ps_rf_wdt,
  output logic                   astat_mv,
  output logic                   astat_mn,
  output logic                   stky_mos
);

  logic [1:0]             d_cls, d_sc;
  logic                   d_otreg;
  logic [3:0]             d_dtsts;
  logic [RF_ADDRSIZE-1:0] d_rn, d_rx, d_ry;
  logic                   unused_rsvd;

  assign d_cls       = ins_if.ins_word[CLS_HI:CLS_LO];
  assign d_sc        = ins_if.ins_word[SC_HI:SC_LO];
  assign d_otreg     = ins_if.ins_word[OTREG_BIT];
  assign d_dtsts     = ins_if.ins_word[DTSTS_HI:DTSTS_LO];
  assign d_rn        = RF_ADDRSIZE'(ins_if.ins_word[RN_HI:RN_LO]);
  assign d_rx        = RF_ADDRSIZE'(ins_if.ins_word[RX_HI:RX_LO]);
  assign d_ry        = RF_ADDRSIZE'(ins_if.ins_word[RY_HI:RY_LO]);
  assign unused_rsvd = ^ins_if.ins_word[DTSTS_LO-1:RN_HI+1];

  logic                   i_valid_q, i_valid_d;
  logic [1:0]             i_cls_q, i_cls_d, i_sc_q, i_sc_d;
  logic                   i_otreg_q, i_otreg_d;
  logic [3:0]             i_dtsts_q, i_dtsts_d;
  logic [RF_ADDRSIZE-1:0] i_rn_q, i_rn_d, i_rx_q, i_rx_d, i_ry_q, i_ry_d;

  logic                   e_valid_q, e_valid_d;
  logic                   e_wr_q, e_wr_d;
  logic [1:0]             e_cls_q, e_cls_d, e_sc_q, e_sc_d;
  logic [RF_ADDRSIZE-1:0] e_rn_q, e_rn_d;

  logic interlock, accept, advance;

  // Only the I-stage write matters: by E the result reaches the RF before the dependent reads it.
  assign interlock = i_valid_q && writes_rn(i_otreg_q) &&
                     ((uses_rx(d_cls, d_sc, d_otreg) && (d_rx == i_rn_q)) ||
                      (uses_ry(d_cls) && (d_ry == i_rn_q)));

  assign ins_if.ins_ready = reset && !interlock && !ps_flush;
  assign accept           = ins_if.ins_valid && ins_if.ins_ready;
  assign advance          = i_valid_q && !ps_flush;

  always_comb begin
    i_valid_d = accept;
    i_cls_d   = i_cls_q;
    i_sc_d    = i_sc_q;
    i_otreg_d = i_otreg_q;
    i_dtsts_d = i_dtsts_q;
    i_rn_d    = i_rn_q;
    i_rx_d    = i_rx_q;
    i_ry_d    = i_ry_q;
    if (accept) begin
      i_cls_d   = d_cls;
      i_sc_d    = d_sc;
      i_otreg_d = d_otreg;
      i_dtsts_d = d_dtsts;
      i_rn_d    = d_rn;
      i_rx_d    = d_rx;
      i_ry_d    = d_ry;
    end
  end

  always_comb begin
    e_valid_d = advance;
    e_wr_d    = e_wr_q;
    e_cls_d   = e_cls_q;
    e_sc_d    = e_sc_q;
    e_rn_d    = e_rn_q;
    if (advance) begin
      e_wr_d  = writes_rn(i_otreg_q);
      e_cls_d = i_cls_q;
      e_sc_d  = i_sc_q;
      e_rn_d  = i_rn_q;
    end
  end

  always_ff @(posedge clk_exe) begin
    if (!reset) begin
      i_valid_q <= 1'b0;
      i_cls_q   <= '0;
      i_sc_q    <= '0;
      i_otreg_q <= 1'b0;
      i_dtsts_q <= '0;
      i_rn_q    <= '0;
      i_rx_q    <= '0;
      i_ry_q    <= '0;
      e_valid_q <= 1'b0;
      e_wr_q    <= 1'b0;
      e_cls_q   <= '0;
      e_sc_q    <= '0;
      e_rn_q    <= '0;
    end else begin
      i_valid_q <= i_valid_d;
      i_cls_q   <= i_cls_d;
      i_sc_q    <= i_sc_d;
      i_otreg_q <= i_otreg_d;
      i_dtsts_q <= i_dtsts_d;
      i_rn_q    <= i_rn_d;
      i_rx_q    <= i_rx_d;
      i_ry_q    <= i_ry_d;
      e_valid_q <= e_valid_d;
      e_wr_q    <= e_wr_d;
      e_cls_q   <= e_cls_d;
      e_sc_q    <= e_sc_d;
      e_rn_q    <= e_rn_d;
    end
  end

  assign ps_mul_en    = i_valid_q;
  assign ps_mul_otreg = i_otreg_q;
  assign ps_mul_dtsts = i_dtsts_q;
  assign ps_mul_cls   = i_cls_q;
  assign ps_mul_sc    = i_sc_q;
  assign ps_xb_rdx    = i_rx_q;
  assign ps_xb_rdy    = i_ry_q;

  assign ps_rf_wen  = e_valid_q && e_wr_q;
  assign ps_rf_wadd = e_rn_q;
  assign ps_rf_wdt  = mul_xb_dt;

  mul_flag_reg u_flag_reg (
    .clk_exe    (clk_exe),
    .reset      (reset),
    .upd_i      (e_valid_q && ((e_cls_q != CLS_MR_SAT) || (e_sc_q == SC_SAT))),
    .mv_i       (mul_ps_mv),
    .mn_i       (mul_ps_mn),
    .stky_clr_i (ps_stky_clr),
    .astat_mv_o (astat_mv),
    .astat_mn_o (astat_mn),
    .stky_mos_o (stky_mos)
  );

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb/tb_mul_issue_ctrl.sv - directed self-checking bench for mul_issue_ctrl
module tb_mul_issue_ctrl;

  logic        clk_exe = 1'b0;
  logic        reset   = 1'b0;
  logic        ps_flush = 1'b0;
  logic        ps_stky_clr = 1'b0;
  logic        ps_mul_en, ps_mul_otreg;
  logic [3:0]  ps_mul_dtsts;
  logic [1:0]  ps_mul_cls, ps_mul_sc;
  logic [3:0]  ps_xb_rdx, ps_xb_rdy;
  logic [15:0] mul_xb_dt = 16'h0000;
  logic        mul_ps_mv = 1'b0;
  logic        mul_ps_mn = 1'b0;
  logic        ps_rf_wen;
  logic [3:0]  ps_rf_wadd;
  logic [15:0] ps_rf_wdt;
  logic        astat_mv, astat_mn, stky_mos;

  int n_cmp = 0;
  int n_mis = 0;

  mul_issue_ctrl_if ins_if();

  mul_issue_ctrl #(.RF_DATASIZE(16), .RF_ADDRSIZE(4)) dut (
    .clk_exe      (clk_exe),
    .reset        (reset),
    .ins_if       (ins_if),
    .ps_flush     (ps_flush),
    .ps_stky_clr  (ps_stky_clr),
    .ps_mul_en    (ps_mul_en),
    .ps_mul_otreg (ps_mul_otreg),
    .ps_mul_dtsts (ps_mul_dtsts),
    .ps_mul_cls   (ps_mul_cls),
    .ps_mul_sc    (ps_mul_sc),
    .ps_xb_rdx    (ps_xb_rdx),
    .ps_xb_rdy    (ps_xb_rdy),
    .mul_xb_dt    (mul_xb_dt),
    .mul_ps_mv    (mul_ps_mv),
    .mul_ps_mn    (mul_ps_mn),
    .ps_rf_wen    (ps_rf_wen),
    .ps_rf_wadd   (ps_rf_wadd),
    .ps_rf_wdt    (ps_rf_wdt),
    .astat_mv     (astat_mv),
    .astat_mn     (astat_mn),
    .stky_mos     (stky_mos)
  );

  always #5 clk_exe = ~clk_exe;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] mk(input logic [1:0] cls, input logic [1:0] sc, input logic otreg,
                                     input logic [3:0] dtsts, input logic [3:0] rn,
                                     input logic [3:0] rx, input logic [3:0] ry);
    return {cls, sc, otreg, dtsts, 3'b000, rn, rx, ry};
  endfunction

  // Inputs change just after the falling edge; checks follow 1 time unit later, mid-cycle.
  task automatic step();
    @(negedge clk_exe);
  endtask

  task automatic issue(input logic [23:0] w);
    step();
    ins_if.ins_valid = 1'b1;
    ins_if.ins_word  = w;
  endtask

  initial begin
    ins_if.ins_valid = 1'b1;
    ins_if.ins_word  = mk(2'b01, 2'b00, 1'b0, 4'b1100, 4'd3, 4'd1, 4'd2);

    step(); #1;
    chk("rst_ready", ins_if.ins_ready, 0);
    chk("rst_en", ps_mul_en, 0);
    chk("rst_wen", ps_rf_wen, 0);
    chk("rst_mv", astat_mv, 0);
    chk("rst_rdx", ps_xb_rdx, 0);
    step();
    reset = 1'b1;
    ins_if.ins_valid = 1'b0;

    // single product: rn=3 rx=1 ry=2 SSI
    issue(mk(2'b01, 2'b00, 1'b0, 4'b1100, 4'd3, 4'd1, 4'd2)); #1;
    chk("p_ready", ins_if.ins_ready, 1);
    step(); ins_if.ins_valid = 1'b0; #1;
    chk("p_en", ps_mul_en, 1);
    chk("p_rdx", ps_xb_rdx, 1);
    chk("p_rdy", ps_xb_rdy, 2);
    chk("p_dtsts", ps_mul_dtsts, 4'b1100);
    chk("p_cls", ps_mul_cls, 1);
    chk("p_wen_early", ps_rf_wen, 0);
    step(); mul_xb_dt = 16'h1234; #1;
    chk("p_wen", ps_rf_wen, 1);
    chk("p_wadd", ps_rf_wadd, 3);
    chk("p_wdt", ps_rf_wdt, 16'h1234);
    chk("p_en_off", ps_mul_en, 0);
    step(); #1;
    chk("p_wen_off", ps_rf_wen, 0);
    chk("p_rdx_hold", ps_xb_rdx, 1);

    // RAW interlock on r5
    issue(mk(2'b01, 2'b00, 1'b0, 4'b0000, 4'd5, 4'd1, 4'd2)); #1;
    chk("raw_a_ready", ins_if.ins_ready, 1);
    issue(mk(2'b01, 2'b00, 1'b0, 4'b0000, 4'd6, 4'd5, 4'd2)); #1;
    chk("raw_stall", ins_if.ins_ready, 0);
    chk("raw_a_en", ps_mul_en, 1);
    step(); #1;
    chk("raw_b_ready", ins_if.ins_ready, 1);
    chk("raw_bubble", ps_mul_en, 0);
    chk("raw_a_wadd", ps_rf_wadd, 5);
    step(); ins_if.ins_valid = 1'b0; #1;
    chk("raw_b_en", ps_mul_en, 1);
    chk("raw_b_rdx", ps_xb_rdx, 5);
    step(); #1;
    chk("raw_b_wen", ps_rf_wen, 1);
    chk("raw_b_wadd", ps_rf_wadd, 6);

    // MRx=Rn behind a write to r5 reads ry=5 but Ry is unused
    issue(mk(2'b01, 2'b00, 1'b0, 4'b0000, 4'd5, 4'd1, 4'd1)); #1;
    issue(mk(2'b00, 2'b01, 1'b1, 4'b0000, 4'd0, 4'd3, 4'd5)); #1;
    chk("nfi_ready", ins_if.ins_ready, 1);
    step(); ins_if.ins_valid = 1'b0; #1;
    chk("nfi_en", ps_mul_en, 1);
    chk("nfi_rdx", ps_xb_rdx, 3);
    chk("nfi_a_wen", ps_rf_wen, 1);
    chk("nfi_a_wadd", ps_rf_wadd, 5);
    step(); #1;
    chk("nfi_b_nowr", ps_rf_wen, 0);

    // SAT MR with mv=mn=1
    issue(mk(2'b00, 2'b11, 1'b0, 4'b0000, 4'd7, 4'd2, 4'd0)); #1;
    chk("sat_ready", ins_if.ins_ready, 1);
    step(); ins_if.ins_valid = 1'b0; #1;
    chk("sat_en", ps_mul_en, 1);
    step(); mul_ps_mv = 1'b1; mul_ps_mn = 1'b1; #1;
    chk("sat_wadd", ps_rf_wadd, 7);
    step(); mul_ps_mv = 1'b0; mul_ps_mn = 1'b0; #1;
    chk("sat_mv", astat_mv, 1);
    chk("sat_mn", astat_mn, 1);
    chk("sat_mos", stky_mos, 1);

    // Rn=MR0 does not update flags
    issue(mk(2'b00, 2'b00, 1'b0, 4'b0000, 4'd1, 4'd0, 4'd0));
    step(); ins_if.ins_valid = 1'b0;
    step(); #1;
    chk("mr0_wen", ps_rf_wen, 1);
    step(); #1;
    chk("mr0_mv_hold", astat_mv, 1);
    chk("mr0_mn_hold", astat_mn, 1);

    step(); ps_stky_clr = 1'b1;
    step(); ps_stky_clr = 1'b0; #1;
    chk("mos_clr", stky_mos, 0);

    // set wins over coincident clear
    issue(mk(2'b01, 2'b00, 1'b0, 4'b0000, 4'd2, 4'd3, 4'd4));
    step(); ins_if.ins_valid = 1'b0;
    step(); mul_ps_mv = 1'b1; mul_ps_mn = 1'b0; ps_stky_clr = 1'b1;
    step(); mul_ps_mv = 1'b0; ps_stky_clr = 1'b0; #1;
    chk("mos_setclr", stky_mos, 1);
    chk("prod_mv", astat_mv, 1);
    chk("prod_mn", astat_mn, 0);

    // flush with A in E and B in I
    issue(mk(2'b01, 2'b00, 1'b0, 4'b0000, 4'd8, 4'd1, 4'd1));
    issue(mk(2'b01, 2'b00, 1'b0, 4'b0000, 4'd9, 4'd1, 4'd1)); #1;
    chk("fl_b_ready", ins_if.ins_ready, 1);
    issue(mk(2'b01, 2'b00, 1'b0, 4'b0000, 4'd10, 4'd1, 4'd1)); ps_flush = 1'b1; #1;
    chk("fl_ready", ins_if.ins_ready, 0);
    chk("fl_a_wen", ps_rf_wen, 1);
    chk("fl_a_wadd", ps_rf_wadd, 8);
    step(); ins_if.ins_valid = 1'b0; ps_flush = 1'b0; #1;
    chk("fl_en", ps_mul_en, 0);
    chk("fl_b_nowr", ps_rf_wen, 0);
    step(); #1;
    chk("fl_b_nowr2", ps_rf_wen, 0);

    // reset with I and E both occupied
    issue(mk(2'b01, 2'b01, 1'b0, 4'b1110, 4'd4, 4'd1, 4'd1));
    issue(mk(2'b10, 2'b01, 1'b0, 4'b1110, 4'd11, 4'd6, 4'd7));
    step(); ins_if.ins_valid = 1'b0; reset = 1'b0; #1;
    chk("mr_ready", ins_if.ins_ready, 0);
    chk("mr_pre_en", ps_mul_en, 1);
    step(); reset = 1'b1; #1;
    chk("mr_en", ps_mul_en, 0);
    chk("mr_wen", ps_rf_wen, 0);
    chk("mr_cls", ps_mul_cls, 0);
    chk("mr_dtsts", ps_mul_dtsts, 0);
    chk("mr_rdx", ps_xb_rdx, 0);
    chk("mr_rdy", ps_xb_rdy, 0);
    chk("mr_mv", astat_mv, 0);
    chk("mr_mos", stky_mos, 0);
    step(); #1;
    chk("mr_nowr", ps_rf_wen, 0);
    chk("mr_noen", ps_mul_en, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
